busio_target: RTL and testbench
===============================

BUSIO_TARGET -- requirements
Module: busio_target

Interface
REQ-001 SHALL have parameter AW, default 20, meaning memory word address width.
REQ-002 SHALL have parameter DW, default 64, meaning data word width.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all logic on posedge.
- reset_n  input  1  synchronous reset, active-low.
- arx  input  2  register index: 0 ADDR, 1 CMD, 2 RDATA, 3 WDATA.
- ecx  input  1  port enable.
- wrx  input  1  direction: 1 = port drives dout, 0 = port captures din.
- astb  input  1  address strobe.
- rd  input  1  memory read request.
- wr  input  1  memory write request.
- iack  input  1  interrupt acknowledge.
- din  input  DW  data from initiator.
- dout  output  DW  data to initiator.
- busy  output  1  memory cycle outstanding; initiator uses it as suspend.
- err  output  1  sticky protocol error.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_ready  input  1  memory completion, one-cycle pulse.
- mem_rdata  input  DW  memory read data, valid with mem_ready.
- irq_vec  input  DW  pending interrupt vector.

Function
REQ-004 SHALL hold four registers: RG0 ADDR (AW bits), RG1 CMD, RG2 RDATA and RG3 WDATA (DW bits each).
REQ-005 SHALL, on ecx & !wrx, write din into register arx; RG0 takes din[AW-1:0].
REQ-006 SHALL drive dout combinationally as register arx (RG0 zero-extended) when ecx & wrx, else zero.
REQ-007 SHALL set addr_valid on astb & ecx & !wrx & arx==ADDR, in the same cycle RG0 loads.
REQ-008 SHALL implement FSM states IDLE, RDWAIT, WRWAIT.
REQ-009 SHALL, in IDLE on rd & !wr & addr_valid, enter RDWAIT, latch the destination (RG1 if arx==CMD, else RG2), and assert mem_req=1, mem_we=0, mem_addr=RG0 from the next cycle.
REQ-010 SHALL, in IDLE on wr & !rd & addr_valid, enter WRWAIT and assert mem_req=1, mem_we=1, mem_wdata=RG3.
REQ-011 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ready.
REQ-012 SHALL, on mem_ready in RDWAIT, load mem_rdata into the latched destination and return to IDLE; the data is readable on the next cycle.
REQ-013 SHALL, on mem_ready in WRWAIT, return to IDLE.
REQ-014 SHALL assert busy combinationally in RDWAIT and WRWAIT, and also in the IDLE cycle that accepts rd or wr.
REQ-015 SHALL ignore mem_ready in IDLE.
REQ-016 SHALL, on iack in IDLE, load RG2 with irq_vec in one cycle without a memory cycle.
REQ-017 SHALL set err and start no cycle on any of:
- rd & wr together.
- rd or wr without addr_valid.
- rd, wr, iack or astb while busy.
REQ-018 SHALL clear err only by reset.
REQ-019 SHALL give a host write to RG2 priority over a same-cycle memory capture.

Reset
REQ-020 SHALL, on reset_n=0 at posedge, force:
- FSM to IDLE.
- RG0-RG3, addr_valid and err to 0.
- mem_req, mem_we and busy to 0.
- mem_addr and mem_wdata to 0.
REQ-021 SHALL let reset mid-cycle abandon the outstanding memory operation; a later mem_ready is ignored.

Configuration
REQ-022 SHALL recognise macro BUSIO_AUTOINC_EN.
REQ-023 With BUSIO_AUTOINC_EN defined, SHALL:
- increment RG0 modulo 2^AW on each mem_ready completion.
- keep addr_valid set, so back-to-back rd/wr proceed without a new astb (block transfer).
REQ-024 Without BUSIO_AUTOINC_EN, SHALL leave RG0 unchanged after a completion and clear addr_valid, so each rd/wr needs a fresh astb.

Structure
REQ-025 SHALL take the reg_index enum (ADDR, CMD, RDATA, WDATA) and the FSM state enum from a shared package busio_pkg.
REQ-026 SHALL be a single module with no sub-modules; the register file is inline.

Verification
REQ-027 Bench SHALL cover:
- Read: astb RG0=0x00123, then rd arx=RDATA; mem_ready after 3 cycles with 0xDEAD_BEEF -> mem_addr=0x00123, mem_we=0, busy high 4 cycles, RG2 reads 0xDEAD_BEEF.
- Write: RG3=0x55, astb RG0=0x10, wr -> mem_we=1, mem_wdata=0x55, busy drops after mem_ready, err=0.
- Fetch: rd arx=CMD -> data lands in RG1, RG2 unchanged.
- Errors: rd & wr together -> err=1, mem_req stays 0; rd with no prior astb -> err=1.
- Auto-increment with BUSIO_AUTOINC_EN: RG0=0xFFFFF, two reads -> addresses 0xFFFFF then 0x00000. Without the macro, the second rd -> err=1.
- iack with irq_vec=0x7 -> RG2=7 next cycle; reset_n low during RDWAIT -> IDLE, a later mem_ready leaves RG2 at 0.

Source files
------------

// File: rtl/busio_pkg.sv
// Shared types for the busio target: register index and memory-cycle FSM state.
// Pure type definitions; no logic, no latency.
package busio_pkg;
  typedef enum logic [1:0] {
    ADDR  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } reg_index_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    WRWAIT = 2'd2
  } state_t;
endpackage

// File: rtl/busio_if.sv
// Initiator register port plus memory-side request/response bundle of busio_target.
// slave = the target itself, master = whoever drives the initiator and memory sides.
interface busio_if #(
  parameter int AW = 20,
  parameter int DW = 64
);
  busio_pkg::reg_index_t arx;
  logic          ecx;
  logic          wrx;
  logic          astb;
  logic          rd;
  logic          wr;
  logic          iack;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          busy;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] irq_vec;

  modport slave (
    input  arx, ecx, wrx, astb, rd, wr, iack, din, mem_ready, mem_rdata, irq_vec,
    output dout, busy, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output arx, ecx, wrx, astb, rd, wr, iack, din, mem_ready, mem_rdata, irq_vec,
    input  dout, busy, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/busio_target.sv
// Register-mapped bus target issuing one memory read/write at a time; busy suspends the initiator
// until mem_ready (request registered one cycle after accept). BUSIO_AUTOINC_EN enables block transfers.
module busio_target
  import busio_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 64
) (
  input logic   clk,
  input logic   reset_n,
  busio_if.slave bus
);

  logic [AW-1:0] rg0;
  logic [DW-1:0] rg1;
  logic [DW-1:0] rg2;
  logic [DW-1:0] rg3;
  logic          addr_valid;
  logic          dest_cmd;
  logic          err_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  state_t        state;

  logic          idle;
  logic          host_wr;
  logic          accept_rd;
  logic          accept_wr;
  logic          err_set;
  logic [DW-1:0] dout_c;

  assign idle      = (state == IDLE);
  assign host_wr   = bus.ecx & ~bus.wrx;
  assign accept_rd = idle & bus.rd & ~bus.wr & addr_valid;
  assign accept_wr = idle & bus.wr & ~bus.rd & addr_valid;

  // "Busy" for protocol errors means a cycle already outstanding, not the accepting cycle.
  assign err_set = (bus.rd & bus.wr)
                 | (idle & (bus.rd | bus.wr) & ~addr_valid)
                 | (~idle & (bus.rd | bus.wr | bus.iack | bus.astb));

  always_comb begin
    dout_c = '0;
    if (bus.ecx && bus.wrx) begin
      case (bus.arx)
        ADDR:    dout_c = {{(DW-AW){1'b0}}, rg0};
        CMD:     dout_c = rg1;
        RDATA:   dout_c = rg2;
        WDATA:   dout_c = rg3;
        default: dout_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rg0         <= '0;
      rg1         <= '0;
      rg2         <= '0;
      rg3         <= '0;
      addr_valid  <= 1'b0;
      dest_cmd    <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept_rd) begin
            state      <= RDWAIT;
            dest_cmd   <= (bus.arx == CMD);
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= rg0;
          end else if (accept_wr) begin
            state       <= WRWAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= rg0;
            mem_wdata_q <= rg3;
          end
          if (bus.iack) begin
            rg2 <= bus.irq_vec;
          end
        end
        RDWAIT, WRWAIT: begin
          if (bus.mem_ready) begin
            if (state == RDWAIT) begin
              if (dest_cmd) rg1 <= bus.mem_rdata;
              else          rg2 <= bus.mem_rdata;
            end
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef BUSIO_AUTOINC_EN
            rg0 <= rg0 + AW'(1);
`else
            addr_valid <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Host writes come last so they win over a same-cycle memory capture or increment.
      if (host_wr) begin
        case (bus.arx)
          ADDR: begin
            rg0 <= bus.din[AW-1:0];
            if (bus.astb) addr_valid <= 1'b1;
          end
          CMD:     rg1 <= bus.din;
          RDATA:   rg2 <= bus.din;
          WDATA:   rg3 <= bus.din;
          default: ;
        endcase
      end
    end
  end

  assign bus.dout      = dout_c;
  assign bus.busy      = ~idle | accept_rd | accept_wr;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_busio_target.sv
// Bench for busio_target: register table, scoreboarded memory cycles, error and reset corners.
module tb_busio_target;
  import busio_pkg::*;

  localparam int AW = 20;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  busio_if #(.AW(AW), .DW(DW)) bus ();
  busio_target #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    reg_index_t    idx;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arx = ADDR; bus.ecx = 1'b0; bus.wrx = 1'b0; bus.astb = 1'b0;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.iack = 1'b0; bus.din = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.irq_vec = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic reg_wr(input reg_index_t idx, input logic [DW-1:0] d, input logic strobe);
    step();
    bus.ecx = 1'b1; bus.wrx = 1'b0; bus.arx = idx; bus.din = d; bus.astb = strobe;
    step();
    bus.ecx = 1'b0; bus.astb = 1'b0; bus.din = '0;
  endtask

  task automatic reg_rd(input reg_index_t idx, output logic [DW-1:0] d);
    bus.ecx = 1'b1; bus.wrx = 1'b1; bus.arx = idx;
    #1;
    d = bus.dout;
    bus.ecx = 1'b0; bus.wrx = 1'b0;
    #1;
  endtask

  // Issue one rd/wr pulse, answer with mem_ready lat cycles after mem_req appears... counted from the pulse.
  task automatic mem_op(input logic is_wr, input reg_index_t dst, input int lat,
                        input logic [DW-1:0] rdata, input logic [AW-1:0] eaddr,
                        input logic [DW-1:0] ewdata, output int bcyc);
    exp_t e;
    exp_t got_e;
    bit   got;
    e.we = is_wr; e.addr = eaddr; e.wdata = ewdata;
    step();
    bus.arx = dst; bus.ecx = 1'b0;
    if (is_wr) bus.wr = 1'b1; else bus.rd = 1'b1;
    sb.push_back(e);
    #1;
    bcyc = bus.busy ? 1 : 0;
    step();
    bus.rd = 1'b0; bus.wr = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      #1;
      if (bus.busy) bcyc++;
      if (got) chk("mem_req_hold", bus.mem_req, 1);
      if (bus.mem_req && !got && sb.size() > 0) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        chk("mem_we", bus.mem_we, got_e.we);
        chk("mem_addr", bus.mem_addr, got_e.addr);
        if (got_e.we) chk("mem_wdata", bus.mem_wdata, got_e.wdata);
      end
      if (c == lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
      end
      step();
      bus.mem_ready = 1'b0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL mem_req_seen: got 0, expected 1 within %0d cycles", lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int            bc;

    vecs[0] = '{ADDR,  64'hFFFF_FFFF_FFF1_2345, 64'h0000_0000_0001_2345};
    vecs[1] = '{CMD,   64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{RDATA, 64'hA5A5_0000_FFFF_5A5A, 64'hA5A5_0000_FFFF_5A5A};
    vecs[3] = '{WDATA, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    vecs[4] = '{ADDR,  64'h0000_0000_000F_FFFF, 64'h0000_0000_000F_FFFF};

    do_reset();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    for (int i = 0; i < 4; i++) begin
      reg_rd(reg_index_t'(i), d);
      chk("rst_reg", d, 0);
    end

    foreach (vecs[i]) begin
      reg_wr(vecs[i].idx, vecs[i].din, 1'b0);
      reg_rd(vecs[i].idx, d);
      chk("reg_readback", d, vecs[i].exp);
    end
    bus.ecx = 1'b0; bus.wrx = 1'b1; bus.arx = CMD;
    #1;
    chk("dout_disabled", bus.dout, 0);
    bus.ecx = 1'b1; bus.wrx = 1'b0;
    #1;
    chk("dout_write_dir", bus.dout, 0);
    bus.ecx = 1'b0;

    // Read into RDATA
    reg_wr(ADDR, 64'h0_0123, 1'b1);
    mem_op(1'b0, RDATA, 3, 64'hDEAD_BEEF, 20'h00123, '0, bc);
    chk("rd_busy_cycles", bc, 4);
    chk("rd_busy_after", bus.busy, 0);
    chk("rd_req_after", bus.mem_req, 0);
    reg_rd(RDATA, d);
    chk("rd_rg2", d, 64'hDEAD_BEEF);

    // Write from WDATA
    reg_wr(WDATA, 64'h55, 1'b0);
    reg_wr(ADDR, 64'h10, 1'b1);
    mem_op(1'b1, RDATA, 2, '0, 20'h00010, 64'h55, bc);
    chk("wr_busy_cycles", bc, 3);
    chk("wr_busy_after", bus.busy, 0);
    chk("wr_err", bus.err, 0);

    // Fetch into CMD
    reg_wr(ADDR, 64'h200, 1'b1);
    mem_op(1'b0, CMD, 1, 64'hCAFE, 20'h00200, '0, bc);
    reg_rd(CMD, d);
    chk("fetch_rg1", d, 64'hCAFE);
    reg_rd(RDATA, d);
    chk("fetch_rg2_kept", d, 64'hDEAD_BEEF);

    // Interrupt acknowledge
    bus.irq_vec = 64'h7;
    step();
    bus.iack = 1'b1;
    #1;
    chk("iack_busy", bus.busy, 0);
    step();
    bus.iack = 1'b0;
    reg_rd(RDATA, d);
    chk("iack_rg2", d, 64'h7);
    chk("iack_mem_req", bus.mem_req, 0);

    // Address wrap / re-strobe requirement
    reg_wr(ADDR, 64'hF_FFFF, 1'b1);
    mem_op(1'b0, RDATA, 1, 64'h1, 20'hFFFFF, '0, bc);
    chk("blk_err0", bus.err, 0);
`ifdef BUSIO_AUTOINC_EN
    mem_op(1'b0, RDATA, 1, 64'h2, 20'h00000, '0, bc);
    chk("blk_err1", bus.err, 0);
    reg_rd(RDATA, d);
    chk("blk_rg2", d, 64'h2);
    reg_rd(ADDR, d);
    chk("blk_rg0", d, 64'h1);
`else
    step();
    bus.rd = 1'b1;
    #1;
    chk("noinc_busy", bus.busy, 0);
    step();
    bus.rd = 1'b0;
    #1;
    chk("noinc_err", bus.err, 1);
    chk("noinc_mem_req", bus.mem_req, 0);
    reg_rd(ADDR, d);
    chk("noinc_rg0", d, 64'hF_FFFF);
`endif

    // rd & wr together
    do_reset();
    #1;
    chk("err_cleared", bus.err, 0);
    reg_wr(ADDR, 64'h5, 1'b1);
    step();
    bus.rd = 1'b1; bus.wr = 1'b1;
    step();
    bus.rd = 1'b0; bus.wr = 1'b0;
    #1;
    chk("rdwr_err", bus.err, 1);
    chk("rdwr_mem_req", bus.mem_req, 0);
    chk("rdwr_busy", bus.busy, 0);

    // rd without astb
    do_reset();
    step();
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    #1;
    chk("noastb_err", bus.err, 1);
    chk("noastb_mem_req", bus.mem_req, 0);

    // astb while a read is outstanding
    do_reset();
    reg_wr(ADDR, 64'h40, 1'b1);
    step();
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    #1;
    chk("busy_req", bus.mem_req, 1);
    chk("busy_err0", bus.err, 0);
    bus.astb = 1'b1;
    step();
    bus.astb = 1'b0;
    #1;
    chk("busy_astb_err", bus.err, 1);
    chk("busy_req_hold", bus.mem_req, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 64'h9;
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("busy_done", bus.busy, 0);

    // Reset while waiting on memory
    do_reset();
    reg_wr(ADDR, 64'h77, 1'b1);
    step();
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    #1;
    chk("rstw_req", bus.mem_req, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("rstw_req_clr", bus.mem_req, 0);
    chk("rstw_busy", bus.busy, 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 64'hBAD;
    step();
    bus.mem_ready = 1'b0;
    reg_rd(RDATA, d);
    chk("rstw_rg2", d, 0);
    chk("rstw_err", bus.err, 0);
    chk("rstw_req_after", bus.mem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
